// File: rtl/final_arbitration_rr.sv
// Round-robin funnel of CHANNEL_COUNT sources into one outbound FWFT FIFO,
// plus an inbound FWFT FIFO routed back to channels by its index field.
module final_arbitration_rr #(
    parameter int CHANNEL_COUNT = 7,
    parameter int MSG_WIDTH     = 16,
    parameter int OUT_DEPTH     = 16,
    parameter int IN_DEPTH      = 16,
    localparam int IDX_WIDTH    = $clog2(CHANNEL_COUNT + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [MSG_WIDTH*CHANNEL_COUNT-1:0] src_data,
    input  logic [CHANNEL_COUNT-1:0]           src_valid,
    output logic [CHANNEL_COUNT-1:0]           src_ready,
    output logic [MSG_WIDTH*CHANNEL_COUNT-1:0] dst_data,
    output logic [CHANNEL_COUNT-1:0]           dst_valid,
    input  logic [CHANNEL_COUNT-1:0]           dst_ready,
    output logic [MSG_WIDTH+IDX_WIDTH-1:0]     final_out_data,
    output logic                               final_out_valid,
    input  logic                               final_out_ready,
    input  logic [MSG_WIDTH+IDX_WIDTH-1:0]     final_in_data,
    input  logic                               final_in_valid,
    output logic                               final_in_ready,
    output logic                               has_flying_messages,
    output logic [15:0]                        drop_count
);

    localparam int WORD_W = MSG_WIDTH + IDX_WIDTH;
    localparam int OA     = $clog2(OUT_DEPTH);
    localparam int OC     = $clog2(OUT_DEPTH + 1);
    localparam int IA     = $clog2(IN_DEPTH);
    localparam int IC     = $clog2(IN_DEPTH + 1);

    // Handshakes stay blocked until the first edge after reset_n rises.
    logic run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    function automatic logic [IDX_WIDTH-1:0] chan_at(
        input logic [IDX_WIDTH-1:0] base,
        input int                   k
    );
        int c;
        c = int'(base) + k;
        if (c >= CHANNEL_COUNT) c = c - CHANNEL_COUNT;
        return IDX_WIDTH'(c);
    endfunction

    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] gnt;
    logic                 gnt_found;

    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            if (!gnt_found && src_valid[chan_at(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt       = chan_at(rr_ptr, k);
            end
        end
    end

    logic [WORD_W-1:0] out_mem [OUT_DEPTH];
    logic [OA-1:0]     out_wr;
    logic [OA-1:0]     out_rd;
    logic [OC-1:0]     out_cnt;
    logic              out_full;
    logic              out_ne;
    logic              out_push;
    logic              out_pop;
    logic [MSG_WIDTH-1:0] src_msg;

    assign out_full = (out_cnt == OC'(OUT_DEPTH));
    assign out_ne   = (out_cnt != '0);
    assign out_push = run && gnt_found && !out_full;
    assign out_pop  = out_ne && final_out_ready;
    assign src_msg  = src_data[int'(gnt)*MSG_WIDTH +: MSG_WIDTH];

    always_comb begin
        src_ready = '0;
        if (out_push) src_ready[gnt] = 1'b1;
    end

    assign final_out_valid = out_ne;
    assign final_out_data  = out_mem[out_rd];

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wr] <= {gnt, src_msg};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr  <= '0;
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_push) begin
                out_wr <= out_wr + OA'(1);
                rr_ptr <= (int'(gnt) == CHANNEL_COUNT - 1) ? '0
                                                           : gnt + IDX_WIDTH'(1);
            end
            if (out_pop) out_rd <= out_rd + OA'(1);
            if (out_push && !out_pop)      out_cnt <= out_cnt + OC'(1);
            else if (!out_push && out_pop) out_cnt <= out_cnt - OC'(1);
        end
    end

    logic [WORD_W-1:0]    in_mem [IN_DEPTH];
    logic [IA-1:0]        in_wr;
    logic [IA-1:0]        in_rd;
    logic [IC-1:0]        in_cnt;
    logic                 in_full;
    logic                 in_ne;
    logic                 in_push;
    logic                 in_pop;
    logic                 in_drop;
    logic [WORD_W-1:0]    head;
    logic [IDX_WIDTH-1:0] head_idx;
    logic [MSG_WIDTH-1:0] head_msg;

    assign in_full        = (in_cnt == IC'(IN_DEPTH));
    assign in_ne          = (in_cnt != '0);
    assign final_in_ready = run && !in_full;
    assign in_push        = final_in_valid && final_in_ready;
    assign head           = in_mem[in_rd];
    assign head_idx       = head[WORD_W-1 -: IDX_WIDTH];
    assign head_msg       = head[MSG_WIDTH-1:0];

    // Out-of-range destinations are discarded without waiting on anyone.
    assign in_drop = in_ne && (int'(head_idx) >= CHANNEL_COUNT);

    always_comb begin
        dst_valid = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            dst_valid[i] = in_ne && (int'(head_idx) == i);
        end
    end

    assign dst_data = {CHANNEL_COUNT{head_msg}};
    assign in_pop   = in_drop || (|(dst_valid & dst_ready));

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr] <= final_in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + IA'(1);
            if (in_pop)  in_rd <= in_rd + IA'(1);
            if (in_push && !in_pop)      in_cnt <= in_cnt + IC'(1);
            else if (!in_push && in_pop) in_cnt <= in_cnt - IC'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count          <= '0;
            has_flying_messages <= 1'b0;
        end else begin
            if (in_drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            has_flying_messages <= (|src_valid) || out_ne || in_ne;
        end
    end

endmodule

// File: tb/tb_final_arbitration_rr.sv
// Randomised and directed checks of final_arbitration_rr against a
// queue-based reference model.
module tb_final_arbitration_rr;

    localparam int CH = 7;
    localparam int MW = 16;
    localparam int OD = 16;
    localparam int ID = 16;
    localparam int IW = 3;
    localparam int WW = MW + IW;

    typedef logic [WW-1:0] word_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [MW*CH-1:0]  src_data;
    logic [CH-1:0]     src_valid;
    logic [CH-1:0]     src_ready;
    logic [MW*CH-1:0]  dst_data;
    logic [CH-1:0]     dst_valid;
    logic [CH-1:0]     dst_ready;
    logic [WW-1:0]     final_out_data;
    logic              final_out_valid;
    logic              final_out_ready;
    logic [WW-1:0]     final_in_data;
    logic              final_in_valid;
    logic              final_in_ready;
    logic              has_flying_messages;
    logic [15:0]       drop_count;

    final_arbitration_rr dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .src_data            (src_data),
        .src_valid           (src_valid),
        .src_ready           (src_ready),
        .dst_data            (dst_data),
        .dst_valid           (dst_valid),
        .dst_ready           (dst_ready),
        .final_out_data      (final_out_data),
        .final_out_valid     (final_out_valid),
        .final_out_ready     (final_out_ready),
        .final_in_data       (final_in_data),
        .final_in_valid      (final_in_valid),
        .final_in_ready      (final_in_ready),
        .has_flying_messages (has_flying_messages),
        .drop_count          (drop_count)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    word_t out_q[$];
    word_t in_q[$];
    int    rr;
    int    drops;
    logic  exp_fly;

    function automatic int exp_grant();
        for (int k = 0; k < CH; k++) begin
            if (src_valid[(rr + k) % CH]) return (rr + k) % CH;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] exp_src_ready();
        logic [CH-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0 && out_q.size() < OD) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_dst_valid();
        logic [CH-1:0] r;
        int d;
        r = '0;
        if (in_q.size() > 0) begin
            d = int'(in_q[0][WW-1:MW]);
            if (d < CH) r[d] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        out_q.delete();
        in_q.delete();
        rr      = 0;
        drops   = 0;
        exp_fly = 1'b0;
    endtask

    task automatic model_tick();
        int    g;
        int    d;
        logic  acc;
        logic  popo;
        logic  ini;
        logic  inpop;
        word_t w;
        g     = exp_grant();
        acc   = (g >= 0) && (out_q.size() < OD);
        popo  = (out_q.size() > 0) && final_out_ready;
        ini   = final_in_valid && (in_q.size() < ID);
        inpop = 1'b0;
        if (in_q.size() > 0) begin
            d = int'(in_q[0][WW-1:MW]);
            if (d >= CH) begin
                inpop = 1'b1;
                if (drops < 65535) drops++;
            end else begin
                inpop = dst_ready[d];
            end
        end
        exp_fly = (|src_valid) || (out_q.size() > 0) || (in_q.size() > 0);
        if (popo) void'(out_q.pop_front());
        if (acc) begin
            w = {IW'(g), src_data[g*MW +: MW]};
            out_q.push_back(w);
            rr = (g + 1) % CH;
        end
        if (inpop) void'(in_q.pop_front());
        if (ini) in_q.push_back(final_in_data);
    endtask

    task automatic finish_cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_src();
        for (int c = 0; c < CH; c++) src_data[c*MW +: MW] = MW'($urandom);
    endtask

    task automatic drain();
        src_valid       = '0;
        final_in_valid  = 1'b0;
        final_out_ready = 1'b1;
        dst_ready       = '1;
        repeat (40) begin
            @(negedge clk);
            finish_cycle();
        end
        @(negedge clk);
        total++;
        if (final_out_valid !== 1'b0 || dst_valid !== '0) begin
            bad++;
            $display("FAIL drain_empty: out_valid=%b dst_valid=%b want 0 0",
                     final_out_valid, dst_valid);
        end
        finish_cycle();
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        src_valid       = '1;
        rand_src();
        final_in_valid  = 1'b1;
        final_in_data   = WW'($urandom);
        final_out_ready = 1'b1;
        dst_ready       = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (src_ready !== '0) begin
            bad++; $display("FAIL reset_src_ready: got %b want 0", src_ready);
        end
        total++;
        if (dst_valid !== '0) begin
            bad++; $display("FAIL reset_dst_valid: got %b want 0", dst_valid);
        end
        total++;
        if (final_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", final_out_valid);
        end
        total++;
        if (final_in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b want 0", final_in_ready);
        end
        total++;
        if (drop_count !== 16'd0 || has_flying_messages !== 1'b0) begin
            bad++;
            $display("FAIL reset_counters: drop=%0d fly=%b want 0 0",
                     drop_count, has_flying_messages);
        end
        src_valid      = '0;
        final_in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            finish_cycle();
        end
        @(negedge clk);
        total++;
        if (final_in_ready !== 1'b1 || has_flying_messages !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b fly=%b want 1 0",
                     final_in_ready, has_flying_messages);
        end
        finish_cycle();
    endtask

    task automatic test_rr_all();
        logic [CH-1:0] want;
        src_valid       = '1;
        final_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_src();
            @(negedge clk);
            want = CH'(1) << (i % CH);
            total++;
            if (src_ready !== want) begin
                bad++; $display("FAIL rr_all_grant%0d: got %b want %b", i, src_ready, want);
            end
            if (i >= 1) begin
                total++;
                if (final_out_data[WW-1:MW] !== IW'((i - 1) % CH) ||
                    final_out_data !== out_q[0]) begin
                    bad++;
                    $display("FAIL rr_all_head%0d: got %h want %h idx %0d",
                             i, final_out_data, out_q[0], (i - 1) % CH);
                end
            end
            finish_cycle();
        end
        drain();
    endtask

    task automatic test_rr_sparse();
        int seq [3] = '{5, 2, 5};
        logic [CH-1:0] want;
        final_out_ready = 1'b1;
        rand_src();
        src_valid = CH'(1) << 2;
        @(negedge clk);
        total++;
        if (src_ready !== src_valid) begin
            bad++; $display("FAIL sparse_prime: got %b want %b", src_ready, src_valid);
        end
        finish_cycle();
        src_valid = (CH'(1) << 2) | (CH'(1) << 5);
        for (int i = 0; i < 3; i++) begin
            rand_src();
            @(negedge clk);
            want = CH'(1) << seq[i];
            total++;
            if (src_ready !== want) begin
                bad++; $display("FAIL sparse_grant%0d: got %b want %b", i, src_ready, want);
            end
            finish_cycle();
        end
        drain();
    endtask

    task automatic test_out_full();
        int accepts = 0;
        final_out_ready = 1'b0;
        src_valid       = '1;
        for (int i = 0; i < 24; i++) begin
            rand_src();
            @(negedge clk);
            if (|(src_ready & src_valid)) accepts++;
            finish_cycle();
        end
        @(negedge clk);
        total++;
        if (accepts != OD) begin
            bad++; $display("FAIL full_accepts: got %0d want %0d", accepts, OD);
        end
        total++;
        if (src_ready !== '0 || final_out_valid !== 1'b1 || final_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_state: src_ready=%b out_valid=%b in_ready=%b want 0 1 1",
                     src_ready, final_out_valid, final_in_ready);
        end
        finish_cycle();
        final_out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (src_ready !== '0 || final_out_data !== out_q[0]) begin
            bad++;
            $display("FAIL full_pop: src_ready=%b head=%h want 0 %h",
                     src_ready, final_out_data, out_q[0]);
        end
        finish_cycle();
        final_out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ($countones(src_ready) != 1 || src_ready !== exp_src_ready()) begin
            bad++;
            $display("FAIL full_refill: got %b want %b", src_ready, exp_src_ready());
        end
        finish_cycle();
        @(negedge clk);
        total++;
        if (src_ready !== '0) begin
            bad++; $display("FAIL full_again: got %b want 0", src_ready);
        end
        finish_cycle();
        drain();
    endtask

    task automatic test_in_stall();
        logic [MW-1:0] pay;
        int hi = 0;
        pay            = MW'($urandom);
        dst_ready      = '0;
        final_in_data  = {IW'(3), pay};
        final_in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (final_in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_in_ready: got %b want 1", final_in_ready);
        end
        finish_cycle();
        final_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dst_ready[3] = 1'b1;
            @(negedge clk);
            if (dst_valid === (CH'(1) << 3)) hi++;
            total++;
            if (dst_valid !== (CH'(1) << 3) || dst_data[3*MW +: MW] !== pay) begin
                bad++;
                $display("FAIL stall_cycle%0d: valid=%b data=%h want %b %h",
                         i, dst_valid, dst_data[3*MW +: MW], CH'(1) << 3, pay);
            end
            finish_cycle();
        end
        dst_ready = '0;
        @(negedge clk);
        total++;
        if (dst_valid !== '0 || hi != 5) begin
            bad++;
            $display("FAIL stall_popped: valid=%b high_cycles=%0d want 0 5", dst_valid, hi);
        end
        finish_cycle();
        drain();
    endtask

    task automatic test_drop();
        logic [MW-1:0] b;
        b              = MW'($urandom);
        dst_ready      = '0;
        final_in_valid = 1'b1;
        final_in_data  = {IW'(7), MW'($urandom)};
        @(negedge clk);
        finish_cycle();
        final_in_data = {IW'(1), b};
        @(negedge clk);
        total++;
        if (dst_valid !== '0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL drop_head: valid=%b drop=%0d want 0 0", dst_valid, drop_count);
        end
        finish_cycle();
        final_in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (drop_count !== 16'd1 || dst_valid !== (CH'(1) << 1) || dst_data[MW-1:0] !== b) begin
            bad++;
            $display("FAIL drop_next: drop=%0d valid=%b data=%h want 1 %b %h",
                     drop_count, dst_valid, dst_data[MW-1:0], CH'(1) << 1, b);
        end
        dst_ready = '1;
        finish_cycle();
        final_in_valid = 1'b1;
        final_in_data  = {IW'(7), MW'($urandom)};
        repeat (65540) begin
            @(negedge clk);
            finish_cycle();
        end
        final_in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            finish_cycle();
        end
        @(negedge clk);
        total++;
        if (drop_count !== 16'hFFFF || drop_count !== 16'(drops)) begin
            bad++;
            $display("FAIL drop_saturate: got %h want ffff (model %0d)", drop_count, drops);
        end
        finish_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_src();
            src_valid       = CH'($urandom);
            final_out_ready = ($urandom_range(0, 1) == 1);
            final_in_valid  = ($urandom_range(0, 3) != 0);
            final_in_data   = {IW'($urandom_range(0, 7)), MW'($urandom)};
            dst_ready       = CH'($urandom & $urandom);
            @(negedge clk);
            total++;
            if (src_ready !== exp_src_ready()) begin
                bad++; $display("FAIL rnd%0d_src_ready: got %b want %b", i, src_ready, exp_src_ready());
            end
            total++;
            if (final_out_valid !== (out_q.size() > 0) ||
                (out_q.size() > 0 && final_out_data !== out_q[0])) begin
                bad++;
                $display("FAIL rnd%0d_out: valid=%b data=%h want %0d entries", i,
                         final_out_valid, final_out_data, out_q.size());
            end
            total++;
            if (final_in_ready !== (in_q.size() < ID)) begin
                bad++; $display("FAIL rnd%0d_in_ready: got %b with %0d queued", i,
                                final_in_ready, in_q.size());
            end
            total++;
            if (dst_valid !== exp_dst_valid() ||
                (in_q.size() > 0 && dst_data !== {CH{in_q[0][MW-1:0]}})) begin
                bad++;
                $display("FAIL rnd%0d_dst: valid=%b want %b", i, dst_valid, exp_dst_valid());
            end
            total++;
            if (drop_count !== 16'(drops) || has_flying_messages !== exp_fly) begin
                bad++;
                $display("FAIL rnd%0d_status: drop=%0d fly=%b want %0d %b", i,
                         drop_count, has_flying_messages, drops, exp_fly);
            end
            finish_cycle();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        final_out_ready = 1'b0;
        dst_ready       = '0;
        for (int i = 0; i < 5; i++) begin
            rand_src();
            src_valid      = CH'(1);
            final_in_valid = 1'b1;
            final_in_data  = {IW'(3), MW'($urandom)};
            @(negedge clk);
            finish_cycle();
        end
        src_valid      = '0;
        final_in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (final_out_valid !== 1'b1 || dst_valid !== (CH'(1) << 3)) begin
            bad++;
            $display("FAIL mid_loaded: out_valid=%b dst_valid=%b want 1 %b",
                     final_out_valid, dst_valid, CH'(1) << 3);
        end
        finish_cycle();
        src_valid = '1;
        reset_n   = 1'b0;
        #1;
        total++;
        if (src_ready !== '0 || dst_valid !== '0 || final_out_valid !== 1'b0 ||
            final_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: src_ready=%b dst_valid=%b out_valid=%b in_ready=%b want all 0",
                     src_ready, dst_valid, final_out_valid, final_in_ready);
        end
        total++;
        if (has_flying_messages !== 1'b0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_async_status: fly=%b drop=%0d want 0 0",
                     has_flying_messages, drop_count);
        end
        @(posedge clk);
        #1;
        src_valid = '0;
        reset_n   = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (final_out_valid !== 1'b0 || has_flying_messages !== 1'b0 || dst_valid !== '0) begin
                bad++;
                $display("FAIL mid_after%0d: out_valid=%b fly=%b dst_valid=%b want 0 0 0",
                         i, final_out_valid, has_flying_messages, dst_valid);
            end
            finish_cycle();
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        src_data        = '0;
        src_valid       = '0;
        dst_ready       = '0;
        final_out_ready = 1'b0;
        final_in_data   = '0;
        final_in_valid  = 1'b0;
        model_reset();
        test_reset();
        test_rr_all();
        test_rr_sparse();
        test_out_full();
        test_in_stall();
        test_drop();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/final_arbitration_rr.md
FINAL_ARBITRATION_RR -- requirements
Module: final_arbitration_rr

Interface
REQ-001 The module SHALL have the following parameters:
- CHANNEL_COUNT, 7, number of local channels (master channels plus the sc channel), 2..64.
- MSG_WIDTH, 16, payload width per channel.
- OUT_DEPTH, 16, outbound FIFO entries, power of two, at least 2.
- IN_DEPTH, 16, inbound FIFO entries, power of two, at least 2.
- IDX_WIDTH = $clog2(CHANNEL_COUNT+1) (derived), channel index field width.

REQ-002 The module SHALL have the following ports:
- clk  in  1  the single clock.
- reset_n  in  1  asynchronous, active-low reset.
- src_data  in  MSG_WIDTH*CHANNEL_COUNT  outbound payloads; channel i occupies bits [(i+1)*MSG_WIDTH-1 : i*MSG_WIDTH].
- src_valid  in  CHANNEL_COUNT  outbound valid, one per channel.
- src_ready  out  CHANNEL_COUNT  outbound accept, one per channel.
- dst_data  out  MSG_WIDTH*CHANNEL_COUNT  inbound payloads, same packing as src_data.
- dst_valid  out  CHANNEL_COUNT  inbound valid, one per channel.
- dst_ready  in  CHANNEL_COUNT  inbound accept, one per channel.
- final_out_data  out  MSG_WIDTH+IDX_WIDTH  outbound word; index in the MSBs, payload in the LSBs.
- final_out_valid  out  1  outbound FIFO not empty.
- final_out_ready  in  1  downstream pops the outbound head.
- final_in_data  in  MSG_WIDTH+IDX_WIDTH  inbound word; destination index in the MSBs.
- final_in_valid  in  1  inbound write.
- final_in_ready  out  1  inbound FIFO not full.
- has_flying_messages  out  1  registered activity flag.
- drop_count  out  16  saturating count of dropped inbound words.

Function
REQ-003 Every handshake SHALL complete in a cycle where valid and ready are both high at the rising clk edge; src_ready SHALL NOT depend on any src_valid other than through the arbiter grant.

REQ-004 The arbiter SHALL hold a round-robin pointer rr_ptr (0..CHANNEL_COUNT-1) and grant the first channel with src_valid high, searching cyclically from rr_ptr upward.

REQ-005 src_ready[g] SHALL be high only for the granted channel g, and only when the outbound FIFO is not full; at most one src_ready bit SHALL be high in any cycle.

REQ-006 On an accepted transfer, the block SHALL write {g, payload} to the outbound FIFO and set rr_ptr to (g+1) mod CHANNEL_COUNT. With no transfer, rr_ptr SHALL hold.

REQ-007 The outbound FIFO SHALL be first-word-fall-through:
- final_out_data presents the head entry;
- final_out_valid is high exactly when occupancy is not 0;
- a pop occurs when final_out_valid and final_out_ready are both high.

REQ-008 A word accepted at edge t SHALL be visible on final_out_data from edge t+1 when the FIFO was empty at edge t.

REQ-009 The outbound FIFO is full when occupancy equals OUT_DEPTH. When full, no source is accepted, even if a pop occurs in the same cycle. A simultaneous push and pop when not full SHALL leave occupancy unchanged.

REQ-010 Read and write pointers SHALL wrap modulo the FIFO depth, and occupancy SHALL be a DEPTH+1-state counter.

REQ-011 The inbound FIFO SHALL follow the same FWFT, full and wrap rules, with depth IN_DEPTH; final_in_ready = not full. A write while full SHALL be ignored.

REQ-012 Inbound routing of the head entry, with destination index d:
- If d < CHANNEL_COUNT: dst_valid[d] is high, every other dst_valid bit is low, and the head is popped when dst_ready[d] is high.
- If d >= CHANNEL_COUNT: no dst_valid bit is raised, the head is popped in that cycle, and drop_count increments, saturating at 16'hFFFF.
- Every dst_data slice SHALL carry the head payload.

REQ-013 has_flying_messages SHALL be registered, equal to the previous cycle's (|src_valid) OR outbound FIFO not empty OR inbound FIFO not empty.

REQ-014 No combinational path SHALL exist from final_out_ready to src_ready, or from final_in_valid to dst_valid.

Reset
REQ-015 When reset_n is low, asynchronously, the block SHALL clear:
- rr_ptr to 0;
- both FIFO pointers and occupancies to 0;
- drop_count and has_flying_messages to 0.
While reset_n is low, src_ready SHALL be 0, dst_valid 0, final_out_valid 0 and final_in_ready 0.

REQ-016 Reset asserted mid-operation SHALL discard all buffered words, with no partial transfer completing. Deassertion SHALL be synchronised internally, so the first handshake can complete at the second rising edge after reset_n rises.

REQ-017 FIFO storage arrays SHALL NOT require reset.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- All 7 src_valid held high, final_out_ready=1 -> grants in order 0,1,...,6,0; the index field on final_out_data follows that sequence, one grant per cycle.
- Only channels 2 and 5 valid, rr_ptr=3 -> channel 5 is granted first, then 2, then 5.
- final_out_ready=0 with sources streaming -> exactly 16 words accepted, final_in unaffected, src_ready all 0 afterwards; one pop -> exactly one further accept on the next cycle.
- Inbound word with index 3, dst_ready[3]=0 for 4 cycles then 1 -> dst_valid[3] is high for 5 cycles and the word is popped on the fifth.
- Inbound index 7 (CHANNEL_COUNT=7) -> no dst_valid, drop_count goes 0->1, the next word is presented the following cycle; 65536 drops -> drop_count = 16'hFFFF.
- reset_n pulsed low with both FIFOs holding 5 words -> all outputs 0 immediately; after release, final_out_valid=0 and has_flying_messages=0 until new traffic arrives.
